seconds_display_driver: RTL



---
 rtl/seconds_display_driver.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seconds_display_driver.sv
// MM.SS driver for a 4-digit multiplexed common-anode seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN darkens the minutes-tens digit when it is zero.
module seconds_display_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    state_t state;

    logic [5:0]  snap_sec;
    logic [5:0]  snap_min;
    logic [13:0] sec_sr;
    logic [13:0] min_sr;
    logic [2:0]  step;
    logic        sec_oor;
    logic        min_oor;

    logic [3:0]  disp_sec_ones;
    logic [3:0]  disp_sec_tens;
    logic [3:0]  disp_min_ones;
    logic [3:0]  disp_min_tens;
    logic        disp_sec_oor;
    logic        disp_min_oor;

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       scan_idx;

    logic [3:0] digit_val;
    logic       digit_dash;
    logic [3:0] an_next;
    logic [6:0] seg_next;

    // One double-dabble iteration: correct each BCD nibble, then shift the whole register.
    function automatic logic [13:0] dabble_step(input logic [13:0] sr);
        logic [13:0] adj;
        adj = sr;
        if (adj[13:10] >= 4'd5) adj[13:10] = adj[13:10] + 4'd3;
        if (adj[9:6] >= 4'd5)   adj[9:6]   = adj[9:6] + 4'd3;
        return {adj[12:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            snap_sec      <= '0;
            snap_min      <= '0;
            sec_sr        <= '0;
            min_sr        <= '0;
            step          <= '0;
            sec_oor       <= 1'b0;
            min_oor       <= 1'b0;
            disp_sec_ones <= '0;
            disp_sec_tens <= '0;
            disp_min_ones <= '0;
            disp_min_tens <= '0;
            disp_sec_oor  <= 1'b0;
            disp_min_oor  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ({min, sec} != {snap_min, snap_sec}) begin
                        snap_sec <= sec;
                        snap_min <= min;
                        sec_sr   <= {8'd0, sec};
                        min_sr   <= {8'd0, min};
                        sec_oor  <= (sec > 6'd59);
                        min_oor  <= (min > 6'd59);
                        step     <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SHIFT: begin
                    sec_sr <= dabble_step(sec_sr);
                    min_sr <= dabble_step(min_sr);
                    step   <= step + 3'd1;
                    if (step == 3'd5) state <= UPDATE;
                end
                UPDATE: begin
                    disp_sec_tens <= sec_sr[13:10];
                    disp_sec_ones <= sec_sr[9:6];
                    disp_min_tens <= min_sr[13:10];
                    disp_min_ones <= min_sr[9:6];
                    disp_sec_oor  <= sec_oor;
                    disp_min_oor  <= min_oor;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        digit_val  = disp_sec_ones;
        digit_dash = disp_sec_oor;
        case (scan_idx)
            2'd0: begin digit_val = disp_sec_ones; digit_dash = disp_sec_oor; end
            2'd1: begin digit_val = disp_sec_tens; digit_dash = disp_sec_oor; end
            2'd2: begin digit_val = disp_min_ones; digit_dash = disp_min_oor; end
            2'd3: begin digit_val = disp_min_tens; digit_dash = disp_min_oor; end
            default: ;
        endcase

        seg_next = digit_dash ? SEG_DASH : seg_decode(digit_val);
        an_next  = ~(4'b0001 << scan_idx);
`ifdef LEADING_ZERO_BLANK_EN
        if (scan_idx == 2'd3 && disp_min_tens == 4'd0 && !disp_min_oor) an_next = 4'b1111;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= SEG_ZERO;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= (scan_idx != 2'd2);
        end
    end

endmodule
